// File: rtl/cdc_nff_sync_filt.sv
// Multi-channel N-flop synchroniser with a per-channel persistence filter and rise/fall pulses.
// Optional CDC_SYNC_GLITCH_EN adds glitch_clr_i / glitch_o sticky abort flags.
module cdc_nff_sync_filt #(
  parameter int                NUM_CH      = 4,
  parameter int                SYNC_STAGES = 2,
  parameter int                FILT_CYCLES = 4,
  parameter logic [NUM_CH-1:0] RST_VAL     = {NUM_CH{1'b0}}
) (
  input  logic              clk_in_b,
  input  logic              arst_master_n,
  input  logic [NUM_CH-1:0] async_i,
`ifdef CDC_SYNC_GLITCH_EN
  input  logic [NUM_CH-1:0] glitch_clr_i,
  output logic [NUM_CH-1:0] glitch_o,
`endif
  output logic [NUM_CH-1:0] sync_o,
  output logic [NUM_CH-1:0] filt_o,
  output logic [NUM_CH-1:0] rise_o,
  output logic [NUM_CH-1:0] fall_o
);

  localparam int CW = $clog2(FILT_CYCLES + 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("cdc_nff_sync_filt: SYNC_STAGES must be >= 2");
  end
  if (FILT_CYCLES < 1) begin : g_bad_filt
    $error("cdc_nff_sync_filt: FILT_CYCLES must be >= 1");
  end
  if (NUM_CH < 1) begin : g_bad_ch
    $error("cdc_nff_sync_filt: NUM_CH must be >= 1");
  end

  logic [NUM_CH-1:0] stage_r [SYNC_STAGES];
  logic [NUM_CH-1:0] sync_s;
  logic [CW-1:0]     cnt_r   [NUM_CH];
  logic [CW-1:0]     cnt_s   [NUM_CH];
  logic [NUM_CH-1:0] filt_r;
  logic [NUM_CH-1:0] filt_s;
  logic [NUM_CH-1:0] rise_r;
  logic [NUM_CH-1:0] rise_s;
  logic [NUM_CH-1:0] fall_r;
  logic [NUM_CH-1:0] fall_s;
`ifdef CDC_SYNC_GLITCH_EN
  logic [NUM_CH-1:0] abort_s;
  logic [NUM_CH-1:0] glitch_r;
`endif

  // Metastability chain: plain flop-to-flop, nothing in between.
  always_ff @(posedge clk_in_b or negedge arst_master_n) begin
    if (!arst_master_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        stage_r[k] <= RST_VAL;
      end
    end else begin
      stage_r[0] <= async_i;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        stage_r[k] <= stage_r[k-1];
      end
    end
  end

  assign sync_s = stage_r[SYNC_STAGES-1];

  // Filter next state: a differing value must persist FILT_CYCLES cycles to be accepted.
  always_comb begin
    filt_s = filt_r;
    rise_s = {NUM_CH{1'b0}};
    fall_s = {NUM_CH{1'b0}};
`ifdef CDC_SYNC_GLITCH_EN
    abort_s = {NUM_CH{1'b0}};
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_s[i] = cnt_r[i];
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (cnt_r[i] == CW'(0)) begin
        if (sync_s[i] != filt_r[i]) begin
          if (FILT_CYCLES == 1) begin
            filt_s[i] = sync_s[i];
            rise_s[i] = sync_s[i];
            fall_s[i] = ~sync_s[i];
          end else begin
            cnt_s[i] = CW'(1);
          end
        end else begin
          cnt_s[i] = CW'(0);
        end
      end else if (sync_s[i] == filt_r[i]) begin
        // Input fell back before acceptance: the change is discarded as a glitch.
        cnt_s[i] = CW'(0);
`ifdef CDC_SYNC_GLITCH_EN
        abort_s[i] = 1'b1;
`endif
      end else if (cnt_r[i] == CW'(FILT_CYCLES - 1)) begin
        cnt_s[i]  = CW'(0);
        filt_s[i] = sync_s[i];
        rise_s[i] = sync_s[i];
        fall_s[i] = ~sync_s[i];
      end else begin
        cnt_s[i] = cnt_r[i] + CW'(1);
      end
    end
  end

  // Filter state, filtered level and edge pulses all update on the same edge.
  always_ff @(posedge clk_in_b or negedge arst_master_n) begin
    if (!arst_master_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_r[i] <= CW'(0);
      end
      filt_r <= RST_VAL;
      rise_r <= {NUM_CH{1'b0}};
      fall_r <= {NUM_CH{1'b0}};
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_r[i] <= cnt_s[i];
      end
      filt_r <= filt_s;
      rise_r <= rise_s;
      fall_r <= fall_s;
    end
  end

`ifdef CDC_SYNC_GLITCH_EN
  // Sticky glitch flags; a new abort wins over a simultaneous clear.
  always_ff @(posedge clk_in_b or negedge arst_master_n) begin
    if (!arst_master_n) begin
      glitch_r <= {NUM_CH{1'b0}};
    end else begin
      glitch_r <= (glitch_r & ~glitch_clr_i) | abort_s;
    end
  end

  assign glitch_o = glitch_r;
`endif

  assign sync_o = sync_s;
  assign filt_o = filt_r;
  assign rise_o = rise_r;
  assign fall_o = fall_r;

endmodule

// File: tb/tb_cdc_nff_sync_filt.sv
// Directed bench: instance a uses defaults (2 stages, filter 4); instance b uses 3 stages, filter 1.
module tb_cdc_nff_sync_filt;

  logic       clk_in_b;
  logic       arst_master_n;
  logic [3:0] async_a, sync_a, filt_a, rise_a, fall_a;
  logic [3:0] async_b, sync_b, filt_b, rise_b, fall_b;
`ifdef CDC_SYNC_GLITCH_EN
  logic [3:0] clr_a, glitch_a, clr_b, glitch_b;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  cdc_nff_sync_filt dut_a (
    .clk_in_b      (clk_in_b),
    .arst_master_n (arst_master_n),
    .async_i       (async_a),
`ifdef CDC_SYNC_GLITCH_EN
    .glitch_clr_i  (clr_a),
    .glitch_o      (glitch_a),
`endif
    .sync_o        (sync_a),
    .filt_o        (filt_a),
    .rise_o        (rise_a),
    .fall_o        (fall_a)
  );

  cdc_nff_sync_filt #(
    .NUM_CH      (4),
    .SYNC_STAGES (3),
    .FILT_CYCLES (1),
    .RST_VAL     (4'h0)
  ) dut_b (
    .clk_in_b      (clk_in_b),
    .arst_master_n (arst_master_n),
    .async_i       (async_b),
`ifdef CDC_SYNC_GLITCH_EN
    .glitch_clr_i  (clr_b),
    .glitch_o      (glitch_b),
`endif
    .sync_o        (sync_b),
    .filt_o        (filt_b),
    .rise_o        (rise_b),
    .fall_o        (fall_b)
  );

  initial clk_in_b = 1'b0;
  always #5 clk_in_b = ~clk_in_b;

  task automatic tick();
    @(posedge clk_in_b);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check filt/rise/fall of instance a together.
  task automatic chk_a(input string tag, input logic [3:0] f, input logic [3:0] r, input logic [3:0] fl);
    chk({tag, ".filt"}, filt_a, f);
    chk({tag, ".rise"}, rise_a, r);
    chk({tag, ".fall"}, fall_a, fl);
  endtask

  initial begin
    arst_master_n = 1'b0;
    async_a = 4'hF;
    async_b = 4'h0;
`ifdef CDC_SYNC_GLITCH_EN
    clr_a = 4'h0;
    clr_b = 4'h0;
`endif
    // 1. Reset hold with toggling inputs
    for (int c = 0; c < 4; c++) begin
      tick();
      async_a = ~async_a;
      chk("rst.sync", sync_a, 4'h0);
      chk_a("rst", 4'h0, 4'h0, 4'h0);
    end
    async_a = 4'h0;
    tick();
    arst_master_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_a("rel", 4'h0, 4'h0, 4'h0);
    end

    // 2. Step on channel 0: sync after edge 2, filt/rise after edge 6
    async_a = 4'h1;
    tick();
    chk("step.e1.sync", sync_a, 4'h0);
    tick();
    chk("step.e2.sync", sync_a, 4'h1);
    tick(); tick(); tick();
    chk_a("step.e5", 4'h0, 4'h0, 4'h0);
    tick();
    chk_a("step.e6", 4'h1, 4'h1, 4'h0);
    tick();
    chk_a("step.e7", 4'h1, 4'h0, 4'h0);

    // 3. Two-cycle pulse on channel 1 is rejected
    async_a = 4'h3;
    tick();
    tick();
    chk("glt.e2.sync", sync_a, 4'h3);
    async_a = 4'h1;
    tick();
    chk("glt.e3.sync", sync_a, 4'h3);
    tick();
    chk("glt.e4.sync", sync_a, 4'h1);
    tick();
`ifdef CDC_SYNC_GLITCH_EN
    chk("glt.flag", glitch_a, 4'h2);
`endif
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_a("glt.hold", 4'h1, 4'h0, 4'h0);
    end
`ifdef CDC_SYNC_GLITCH_EN
    clr_a = 4'h2;
    tick();
    clr_a = 4'h0;
    chk("glt.clr", glitch_a, 4'h0);
`endif

    // Channel 0 back to 0: fall pulse after edge 6
    async_a = 4'h0;
    for (int c = 0; c < 5; c++) tick();
    chk_a("fall.e5", 4'h1, 4'h0, 4'h0);
    tick();
    chk_a("fall.e6", 4'h0, 4'h0, 4'h1);
    tick();
    chk_a("fall.e7", 4'h0, 4'h0, 4'h0);

    // 4. Parallel channels: 0 -> A, then A -> 5
    async_a = 4'hA;
    for (int c = 0; c < 6; c++) tick();
    chk_a("par.a", 4'hA, 4'hA, 4'h0);
    tick();
    chk_a("par.a1", 4'hA, 4'h0, 4'h0);
    async_a = 4'h5;
    for (int c = 0; c < 6; c++) tick();
    chk_a("par.5", 4'h5, 4'h5, 4'hA);
    tick();
    chk_a("par.51", 4'h5, 4'h0, 4'h0);

    // 5. Reset while channels 1 and 3 are pending at cnt=2
    async_a = 4'hF;
    for (int c = 0; c < 4; c++) tick();
    chk("mid.pre.sync", sync_a, 4'hF);
    arst_master_n = 1'b0;
    #1;
    chk("mid.sync", sync_a, 4'h0);
    chk_a("mid", 4'h0, 4'h0, 4'h0);
    tick();
    tick();
    arst_master_n = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    chk_a("mid.e5", 4'h0, 4'h0, 4'h0);
    tick();
    chk_a("mid.e6", 4'hF, 4'hF, 4'h0);

    // 6. FILT_CYCLES=1, 3 stages: one-cycle sync pulse passes through
    async_b = 4'h1;
    tick();
    async_b = 4'h0;
    tick();
    chk("f1.e2.sync", sync_b, 4'h0);
    tick();
    chk("f1.e3.sync", sync_b, 4'h1);
    chk("f1.e3.filt", filt_b, 4'h0);
    tick();
    chk("f1.e4.sync", sync_b, 4'h0);
    chk("f1.e4.filt", filt_b, 4'h1);
    chk("f1.e4.rise", rise_b, 4'h1);
    chk("f1.e4.fall", fall_b, 4'h0);
    tick();
    chk("f1.e5.filt", filt_b, 4'h0);
    chk("f1.e5.rise", rise_b, 4'h0);
    chk("f1.e5.fall", fall_b, 4'h1);
    tick();
    chk("f1.e6.fall", fall_b, 4'h0);
`ifdef CDC_SYNC_GLITCH_EN
    chk("f1.glitch", glitch_b, 4'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
